hazard_scoreboard: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/sb_entry.sv | 34 +++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared CPU constants, register address type, saturating helper
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int NREGS    = 32;
  localparam int REG_AW   = 5;
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  typedef logic [REG_AW-1:0] reg_addr_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sb_entry : one register's countdown counter (clear > load > decrement)
// Rev 1.0
// ----------------------------------------------------------------------------
module sb_entry #(
  parameter int LW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  output logic [LW-1:0] cnt
);

  logic [LW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LW'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_scoreboard : per-register RAW/WAW countdown scoreboard with flush.
// Optional perf counters when HAZARD_SB_PERF_EN is defined.   Rev 1.0
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter  int NREGS   = cpu_pkg::NREGS,
  parameter  int REG_AW  = cpu_pkg::REG_AW,
  parameter  int NSRC    = 2,
  parameter  int LAT_MAX = 3,
  localparam int LW      = $clog2(LAT_MAX + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic [NSRC-1:0]        src_used,
  input  logic [REG_AW-1:0]      dst_addr,
  input  logic                   dst_wen,
  input  logic [LW-1:0]          dst_lat,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy,
  output logic [31:0]            cycle_count,
  output logic [31:0]            stall_count,
  output logic [31:0]            issue_count
);

  import cpu_pkg::*;

  localparam int NADDR = 2 ** REG_AW;

  // Padded to the full address space so any address indexes safely.
  logic [LW-1:0]   w_cnt [NADDR];
  logic [LW-1:0]   w_lat;
  logic [NSRC-1:0] w_raw;
  logic            w_waw;
  logic            w_issue;
  logic            w_load_en;

  always_comb begin
    w_lat = dst_lat;
    if (int'(dst_lat) > LAT_MAX) begin
      w_lat = LW'(LAT_MAX);
    end
  end

  always_comb begin
    w_raw = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_used[k] && (src_addr[k*REG_AW +: REG_AW] != '0) &&
          (w_cnt[src_addr[k*REG_AW +: REG_AW]] != '0)) begin
        w_raw[k] = 1'b1;
      end
    end
  end

  assign w_waw       = dst_wen && (dst_addr != '0) && (w_cnt[dst_addr] > w_lat);
  assign issue_ready = !flush && !(|w_raw) && !w_waw;
  assign w_issue     = issue_valid && issue_ready;
  assign w_load_en   = w_issue && dst_wen && (w_lat != LW'(LAT_ALU));

  for (genvar r = 0; r < NADDR; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_cnt[r] = '0;
      assign busy[r]  = 1'b0;
    end else if (r < NREGS) begin : g_entry
      sb_entry #(
        .LW       (LW)
      ) u_entry (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .load     (w_load_en && (dst_addr == REG_AW'(r))),
        .load_val (w_lat),
        .cnt      (w_cnt[r])
      );
      assign busy[r] = (w_cnt[r] != '0);
    end else begin : g_pad
      assign w_cnt[r] = '0;
    end
  end

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_stall_count;
  logic [31:0] r_issue_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
      r_issue_count <= '0;
    end else begin
      r_cycle_count <= sat_inc(r_cycle_count);
      if (issue_valid && !issue_ready) begin
        r_stall_count <= sat_inc(r_stall_count);
      end
      if (w_issue) begin
        r_issue_count <= sat_inc(r_issue_count);
      end
    end
  end

  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;
  assign issue_count = r_issue_count;
`else
  assign cycle_count = '0;
  assign stall_count = '0;
  assign issue_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard : queue-based self-checking bench for hazard_scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  localparam int NSRC    = 2;
  localparam int LAT_MAX = 3;
  localparam int LW      = 2;
`ifdef HAZARD_SB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   issue_valid = 1'b0;
  logic                   issue_ready;
  logic [NSRC*REG_AW-1:0] src_addr = '0;
  logic [NSRC-1:0]        src_used = '0;
  reg_addr_t              dst_addr = '0;
  logic                   dst_wen = 1'b0;
  logic [LW-1:0]          dst_lat = '0;
  logic                   flush = 1'b0;
  logic [NREGS-1:0]       busy;
  logic [31:0]            cycle_count;
  logic [31:0]            stall_count;
  logic [31:0]            issue_count;

  hazard_scoreboard #(
    .NREGS       (NREGS),
    .REG_AW      (REG_AW),
    .NSRC        (NSRC),
    .LAT_MAX     (LAT_MAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .src_addr    (src_addr),
    .src_used    (src_used),
    .dst_addr    (dst_addr),
    .dst_wen     (dst_wen),
    .dst_lat     (dst_lat),
    .flush       (flush),
    .busy        (busy),
    .cycle_count (cycle_count),
    .stall_count (stall_count),
    .issue_count (issue_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic        rdy;
    logic [31:0] bsy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0;
    src_addr    = '0;
    src_used    = '0;
    dst_addr    = '0;
    dst_wen     = 1'b0;
    dst_lat     = '0;
    flush       = 1'b0;
  endtask

  // One cycle of stimulus plus the ready/busy the cycle must show.
  task automatic cyc(input string tag, input logic v, input logic [4:0] s1, input logic [4:0] s0,
                     input logic [1:0] used, input logic [4:0] d, input logic wen,
                     input logic [1:0] lat, input logic fl, input logic rdy, input logic [31:0] bsy);
    exp_t e;
    @(posedge clock);
    #1;
    issue_valid = v;
    src_addr    = {s1, s0};
    src_used    = used;
    dst_addr    = d;
    dst_wen     = wen;
    dst_lat     = lat;
    flush       = fl;
    e.tag = tag;
    e.rdy = rdy;
    e.bsy = bsy;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_eq({mon_e.tag, "_ready"}, 32'(issue_ready), 32'(mon_e.rdy));
      check_eq({mon_e.tag, "_busy"}, busy, mon_e.bsy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap_cyc, snap_stall, snap_iss;

    #1;
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_ready", 32'(issue_ready), 32'h1);
    check_eq("rst_cycle", cycle_count, 32'h0);
    check_eq("rst_stall", stall_count, 32'h0);
    check_eq("rst_issue", issue_count, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    cyc("t1_nohaz", 1, 5'd6, 5'd5, 2'b11, 5'd0, 0, 2'd0, 0, 1, 32'h0);

    cyc("t2_prod",  1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 2'd1, 0, 1, 32'h0);
    cyc("t2_stall", 1, 5'd0, 5'd5, 2'b01, 5'd0, 0, 2'd0, 0, 0, 32'h20);
    cyc("t2_issue", 1, 5'd0, 5'd5, 2'b01, 5'd0, 0, 2'd0, 0, 1, 32'h0);

    cyc("t3_prod",  1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 2'd3, 0, 1, 32'h0);
    snap_cyc   = cycle_count;
    snap_stall = stall_count;
    snap_iss   = issue_count;
    for (int i = 0; i < 3; i++) begin
      cyc("t3_stall", 1, 5'd0, 5'd5, 2'b01, 5'd0, 0, 2'd0, 0, 0, 32'h20);
    end
    cyc("t3_issue", 1, 5'd0, 5'd5, 2'b01, 5'd0, 0, 2'd0, 0, 1, 32'h0);
    cyc("t3_idle",  0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 0, 1, 32'h0);
    check_eq("t3_stall_delta", stall_count - snap_stall, PERF ? 32'd3 : 32'd0);
    check_eq("t3_cycle_delta", cycle_count - snap_cyc,   PERF ? 32'd5 : 32'd0);
    check_eq("t3_issue_delta", issue_count - snap_iss,   PERF ? 32'd2 : 32'd0);

    cyc("t4_prod", 1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 2'd3, 0, 1, 32'h0);
    cyc("t4_src",  1, 5'd0, 5'd0, 2'b01, 5'd0, 0, 2'd0, 0, 1, 32'h0);

    cyc("t5_prod",   1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 2'd3, 0, 1, 32'h0);
    cyc("t5_waw",    1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 2'd1, 0, 0, 32'h80);
    cyc("t5_waw",    1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 2'd1, 0, 0, 32'h80);
    cyc("t5_issue",  1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 2'd1, 0, 1, 32'h80);
    cyc("t5_reload", 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 0, 1, 32'h80);
    cyc("t5_done",   0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 0, 1, 32'h0);

    cyc("t6_prod",  1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 2'd3, 0, 1, 32'h0);
    cyc("t6_flush", 1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 2'd2, 1, 0, 32'h10);
    cyc("t6_after", 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 0, 1, 32'h0);

    cyc("t7_p5", 1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 2'd3, 0, 1, 32'h0);
    cyc("t7_p7", 1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 2'd3, 0, 1, 32'h20);
    @(posedge clock);
    #1;
    drive_idle();
    check_eq("t7_busy_pre", busy, 32'hA0);
    #1;
    reset = 1'b0;
    #1;
    check_eq("t7_busy_rst", busy, 32'h0);
    check_eq("t7_ready_rst", 32'(issue_ready), 32'h1);
    check_eq("t7_cycle_rst", cycle_count, 32'h0);
    check_eq("t7_stall_rst", stall_count, 32'h0);
    check_eq("t7_issue_rst", issue_count, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    cyc("t8_self", 1, 5'd0, 5'd5, 2'b01, 5'd5, 1, 2'd2, 0, 1, 32'h0);
    cyc("t8_dep",  1, 5'd5, 5'd0, 2'b10, 5'd0, 0, 2'd0, 0, 0, 32'h20);
    cyc("t8_dep",  1, 5'd5, 5'd0, 2'b10, 5'd0, 0, 2'd0, 0, 0, 32'h20);
    cyc("t8_go",   1, 5'd5, 5'd0, 2'b10, 5'd0, 0, 2'd0, 0, 1, 32'h0);
    cyc("t8_idle", 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'd0, 0, 1, 32'h0);

    @(negedge clock);
    #1;
    check_eq("q_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
